// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-bit synchroniser and debouncer for the SWI switch bus with rise/fall pulses
// Optional SW_DEBOUNCE_TOGGLE_EN adds a per-bit latching toggle driven by accepted rises.
module sw_debounce #(
   parameter int NBITS           = 8,
   parameter int DEBOUNCE_CYCLES = 4,
   localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic             clk_2,
   input  logic             reset,
   input  logic [NBITS-1:0] sw_raw,
   output logic [NBITS-1:0] sw_stable,
   output logic [NBITS-1:0] sw_rise,
   output logic [NBITS-1:0] sw_fall,
   output logic             any_change,
   output logic [NBITS-1:0] sw_toggle
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NBITS-1:0] s1;
   logic [NBITS-1:0] s2;
   logic [CNT_W-1:0] cnt   [NBITS];
   logic [CNT_W-1:0] cnt_n [NBITS];
   logic [NBITS-1:0] stable_n;
   logic [NBITS-1:0] rise_n;
   logic [NBITS-1:0] fall_n;

   // A bit is accepted once it has disagreed with sw_stable for DEBOUNCE_CYCLES edges in a row.
   always_comb begin
      stable_n = sw_stable;
      rise_n   = '0;
      fall_n   = '0;
      for (int i = 0; i < NBITS; i++) begin
         cnt_n[i] = '0;
         if (s2[i] != sw_stable[i]) begin
            if (cnt[i] == CNT_MAX) begin
               stable_n[i] = s2[i];
               rise_n[i]   = s2[i];
               fall_n[i]   = ~s2[i];
            end else begin
               cnt_n[i] = cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         s1         <= '0;
         s2         <= '0;
         sw_stable  <= '0;
         sw_rise    <= '0;
         sw_fall    <= '0;
         any_change <= 1'b0;
         for (int i = 0; i < NBITS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1         <= sw_raw;
         s2         <= s1;
         sw_stable  <= stable_n;
         sw_rise    <= rise_n;
         sw_fall    <= fall_n;
         any_change <= |(rise_n | fall_n);
         for (int i = 0; i < NBITS; i++) begin
            cnt[i] <= cnt_n[i];
         end
      end
   end

`ifdef SW_DEBOUNCE_TOGGLE_EN
   logic [NBITS-1:0] toggle_q;

   always_ff @(posedge clk_2) begin
      if (reset) begin
         toggle_q <= '0;
      end else begin
         toggle_q <= toggle_q ^ rise_n;
      end
   end

   assign sw_toggle = toggle_q;
`else
   assign sw_toggle = '0;
`endif

endmodule
